// File: rtl/gpio_loader_pkg.sv
// Shared types and constants for the GPIO serial loader.
package gpio_loader_pkg;

  localparam int CFG_W_DEF    = 13;
  localparam int NUM_PADS_DEF = 19;

  // Bit positions inside the housekeeping control register.
  localparam int CTRL_XFER      = 0;
  localparam int CTRL_BB_EN     = 1;
  localparam int CTRL_BB_RESETN = 2;
  localparam int CTRL_BB_LOAD   = 3;
  localparam int CTRL_BB_CLOCK  = 4;
  localparam int CTRL_BB_DATA1  = 5;
  localparam int CTRL_BB_DATA2  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHRST,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD
  } loader_state_e;

endpackage

// File: rtl/gpio_loader_clkdiv.sv
// Phase timer for the loader: tick_o is high in the (CLK_DIV+1)-th cycle
// after the last restart. Restart is asserted on the edge that enters a new state.
module gpio_loader_clkdiv #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts 13-bit pad configs into both GPIO chains in parallel, farthest pad first.
// Optional bit-bang passthrough in IDLE is enabled by GPIO_LOADER_BITBANG_EN.
//
// state       | meaning
// IDLE        | waiting for xfer_req (or mirroring bb_* in bit-bang mode)
// CHRST       | serial_resetn low for CLK_DIV+1 cycles
// FETCH       | address out, then latch read data into the shift registers
// SHIFT_LO    | serial_clock low, data set up
// SHIFT_HI    | serial_clock high, chains sample on the rising edge
// LOAD        | serial_load high for CLK_DIV+1 cycles
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int NUM_PADS = NUM_PADS_DEF,
  parameter int CFG_W    = CFG_W_DEF,
  parameter int CLK_DIV  = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             xfer_req,
  output logic             busy,
  output logic             done,
  output logic [5:0]       cfg_addr1,
  output logic [5:0]       cfg_addr2,
  input  logic [CFG_W-1:0] cfg_data1,
  input  logic [CFG_W-1:0] cfg_data2,
  input  logic             bb_enable,
  input  logic             bb_resetn,
  input  logic             bb_load,
  input  logic             bb_clock,
  input  logic             bb_data1,
  input  logic             bb_data2,
  output logic             serial_clock,
  output logic             serial_load,
  output logic             serial_resetn,
  output logic             serial_data1,
  output logic             serial_data2
);

  localparam int PW = (NUM_PADS < 2) ? 1 : $clog2(NUM_PADS);
  localparam int BW = (CFG_W < 2) ? 1 : $clog2(CFG_W);
  localparam logic [PW-1:0] PAD_LAST = PW'(NUM_PADS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_W - 1);

  loader_state_e    state_q;
  logic [PW-1:0]    pad_cnt_q;
  logic [PW-1:0]    pad_nxt;
  logic [BW-1:0]    bit_cnt_q;
  logic             fetch_wait_q;
  logic [CFG_W-1:0] shift1_q;
  logic [CFG_W-1:0] shift2_q;
  logic             tick;
  logic             phase_end;
  logic             bb_active;
  logic [4:0]       idle_out;   // {clock, load, resetn, data1, data2}

`ifdef GPIO_LOADER_BITBANG_EN
  assign bb_active = bb_enable;
  assign idle_out  = {bb_clock, bb_load, bb_resetn, bb_data1, bb_data2};
`else
  logic unused_bb;
  assign unused_bb = ^{bb_enable, bb_resetn, bb_load, bb_clock, bb_data1, bb_data2};
  assign bb_active = 1'b0;
  assign idle_out  = 5'b00100;
`endif

  assign pad_nxt = pad_cnt_q + 1'b1;

  always_comb begin
    phase_end = 1'b0;
    case (state_q)
      ST_IDLE:  phase_end = xfer_req && !bb_active;
      ST_FETCH: phase_end = fetch_wait_q;
      default:  phase_end = tick;
    endcase
  end

  gpio_loader_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .restart_i (phase_end),
    .tick_o    (tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      serial_data1  <= 1'b0;
      serial_data2  <= 1'b0;
      cfg_addr1     <= '0;
      cfg_addr2     <= '0;
      pad_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      fetch_wait_q  <= 1'b0;
      shift1_q      <= '0;
      shift2_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy <= 1'b0;
          {serial_clock, serial_load, serial_resetn, serial_data1, serial_data2} <= idle_out;
          if (xfer_req && !bb_active) begin
            state_q       <= ST_CHRST;
            busy          <= 1'b1;
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
            serial_data1  <= 1'b0;
            serial_data2  <= 1'b0;
            pad_cnt_q     <= '0;
            bit_cnt_q     <= '0;
          end
        end
        ST_CHRST: begin
          if (tick) begin
            state_q       <= ST_FETCH;
            serial_resetn <= 1'b1;
            fetch_wait_q  <= 1'b0;
            cfg_addr1     <= 6'(NUM_PADS - 1 - int'(pad_cnt_q));
            cfg_addr2     <= 6'(NUM_PADS + int'(pad_cnt_q));
          end
        end
        ST_FETCH: begin
          if (!fetch_wait_q) begin
            fetch_wait_q <= 1'b1;
          end else begin
            shift1_q     <= cfg_data1;
            shift2_q     <= cfg_data2;
            serial_data1 <= cfg_data1[CFG_W-1];
            serial_data2 <= cfg_data2[CFG_W-1];
            serial_clock <= 1'b0;
            state_q      <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (tick) begin
            serial_clock <= 1'b1;
            state_q      <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            serial_clock <= 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              if (pad_cnt_q == PAD_LAST) begin
                pad_cnt_q    <= '0;
                serial_load  <= 1'b1;
                serial_data1 <= 1'b0;
                serial_data2 <= 1'b0;
                state_q      <= ST_LOAD;
              end else begin
                pad_cnt_q    <= pad_nxt;
                fetch_wait_q <= 1'b0;
                cfg_addr1    <= 6'(NUM_PADS - 1 - int'(pad_nxt));
                cfg_addr2    <= 6'(NUM_PADS + int'(pad_nxt));
                state_q      <= ST_FETCH;
              end
            end else begin
              bit_cnt_q    <= bit_cnt_q + 1'b1;
              shift1_q     <= {shift1_q[CFG_W-2:0], 1'b0};
              shift2_q     <= {shift2_q[CFG_W-2:0], 1'b0};
              serial_data1 <= shift1_q[CFG_W-2];
              serial_data2 <= shift2_q[CFG_W-2];
              state_q      <= ST_SHIFT_LO;
            end
          end
        end
        ST_LOAD: begin
          if (tick) begin
            serial_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader: random pad configs, expected chain
// words queued at issue time and popped by a monitor every 13 serial_clock rises.
module tb_gpio_serial_loader;

  localparam int NP = 19;
  localparam int W  = 13;
  localparam int TOTAL_A = 2 + 2 * 2 + 2 * NP + 2 * NP * W * 2;  // CLK_DIV=1 -> 1032
  localparam int TOTAL_B = 2 + 2 * 1 + 2 * NP + 2 * NP * W * 1;  // CLK_DIV=0 -> 536

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] cfg_mem [0:2*NP-1];

  // DUT A: CLK_DIV = 1
  logic xfer_req = 1'b0;
  logic busy, done, sclk, sload, srstn, sd1, sd2;
  logic [5:0] a1, a2;
  logic [W-1:0] d1, d2;
  // DUT B: CLK_DIV = 0
  logic b_req = 1'b0;
  logic b_busy, b_done, b_sclk, b_sload, b_srstn, b_sd1, b_sd2;
  logic [5:0] b_a1, b_a2;
  logic [W-1:0] b_d1, b_d2;

  logic bb_enable = 1'b0, bb_resetn = 1'b1, bb_load = 1'b0;
  logic bb_clock = 1'b0, bb_data1 = 1'b0, bb_data2 = 1'b0;

  gpio_serial_loader #(.NUM_PADS(NP), .CFG_W(W), .CLK_DIV(1)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .xfer_req(xfer_req), .busy(busy), .done(done),
    .cfg_addr1(a1), .cfg_addr2(a2), .cfg_data1(d1), .cfg_data2(d2),
    .bb_enable(bb_enable), .bb_resetn(bb_resetn), .bb_load(bb_load),
    .bb_clock(bb_clock), .bb_data1(bb_data1), .bb_data2(bb_data2),
    .serial_clock(sclk), .serial_load(sload), .serial_resetn(srstn),
    .serial_data1(sd1), .serial_data2(sd2));

  gpio_serial_loader #(.NUM_PADS(NP), .CFG_W(W), .CLK_DIV(0)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .xfer_req(b_req), .busy(b_busy), .done(b_done),
    .cfg_addr1(b_a1), .cfg_addr2(b_a2), .cfg_data1(b_d1), .cfg_data2(b_d2),
    .bb_enable(bb_enable), .bb_resetn(bb_resetn), .bb_load(bb_load),
    .bb_clock(bb_clock), .bb_data1(bb_data1), .bb_data2(bb_data2),
    .serial_clock(b_sclk), .serial_load(b_sload), .serial_resetn(b_srstn),
    .serial_data1(b_sd1), .serial_data2(b_sd2));

  // Register file with one-cycle read latency.
  function automatic logic [W-1:0] rf(input logic [5:0] addr);
    if (int'(addr) < 2 * NP) return cfg_mem[addr];
    return '0;
  endfunction

  always @(posedge clk) begin
    d1   <= rf(a1);
    d2   <= rf(a2);
    b_d1 <= rf(b_a1);
    b_d2 <= rf(b_a2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard + monitor for DUT A ----------------
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int exp_done_cyc = -1;
  int edges = 0, nbits = 0, loads = 0, dones = 0;
  logic [W-1:0] w1 = '0, w2 = '0, last_w1 = '0, last_w2 = '0;
  logic prev_sclk = 1'b0, prev_load = 1'b0, prev_d1 = 1'b0, prev_d2 = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e1, e2;
    if (rst) begin
      nbits = 0;
      edges = 0;
    end else begin
      if (busy) begin
        if (sclk && !prev_sclk) begin
          w1 = {w1[W-2:0], sd1};
          w2 = {w2[W-2:0], sd2};
          nbits++;
          edges++;
          if (nbits == W) begin
            nbits = 0;
            last_w1 = w1;
            last_w2 = w2;
            if (exp_q1.size() == 0 || exp_q2.size() == 0) begin
              check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
              e1 = exp_q1.pop_front();
              e2 = exp_q2.pop_front();
              check("chain1_pad_word", 32'(w1), 32'(e1));
              check("chain2_pad_word", 32'(w2), 32'(e2));
            end
          end
        end
        if (sclk && prev_sclk)
          check("data_stable_high", {30'd0, sd1, sd2}, {30'd0, prev_d1, prev_d2});
        if (sload && !prev_load) begin
          loads++;
          check("edges_before_load", edges, 247);
          check("scoreboard_drained", exp_q1.size(), 0);
          edges = 0;
        end
      end
      if (done) begin
        dones++;
        check("done_cycle", cyc, exp_done_cyc);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_sclk = sclk;
    prev_load = sload;
    prev_d1   = sd1;
    prev_d2   = sd2;
  end

  // ---------------- monitor for DUT B ----------------
  int b_edges = 0, b_rlow = 0, b_hi_long = 0, b_dones = 0, b_done_cyc = -1;
  logic b_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst && b_busy) begin
      if (!b_srstn) b_rlow++;
      if (b_sclk && !b_prev) b_edges++;
      if (b_sclk && b_prev) b_hi_long++;
    end
    if (!rst && b_done) begin
      b_dones++;
      b_done_cyc = cyc;
    end
    b_prev = b_sclk;
  end

  // ---------------- stimulus ----------------
  task automatic randomize_cfg();
    for (int i = 0; i < 2 * NP; i++) cfg_mem[i] = W'($urandom);
  endtask

  task automatic issue_xfer();
    @(posedge clk); #1;
    exp_q1.delete();
    exp_q2.delete();
    for (int p = NP - 1; p >= 0; p--) exp_q1.push_back(cfg_mem[p]);
    for (int p = NP; p < 2 * NP; p++) exp_q2.push_back(cfg_mem[p]);
    exp_done_cyc = cyc + TOTAL_A - 1;
    check("busy_before_accept", {31'd0, busy}, 32'd0);
    xfer_req = 1'b1;
    @(posedge clk); #1;
    xfer_req = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("resetn_low_chrst", {31'd0, srstn}, 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int start = dones;
    while (dones == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (dones == start) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_edges(input int target, input int budget);
    int n = 0;
    while (edges < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (edges < target) check("edge_wait_timeout", edges, target);
  endtask

  initial begin
    int l0, dn0;
    logic v;
    for (int i = 0; i < 2 * NP; i++) cfg_mem[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", {21'd0, busy, done, sclk, sload, srstn, sd1, sd2, 4'd0},
          32'd0);
    check("reset_addr_a", {20'd0, a1, a2}, 32'd0);
    check("reset_outputs_b", {25'd0, b_busy, b_done, b_sclk, b_sload, b_srstn, b_sd1, b_sd2},
          32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("resetn_rises_after_reset", {31'd0, srstn}, 32'd1);

    // Directed: 0x1809 on pads 0 and 37
    cfg_mem[0]  = 13'h1809;
    cfg_mem[37] = 13'h1809;
    issue_xfer();
    wait_done(3000);
    check("directed_loads", loads, 1);
    check("chain1_tail", 32'(last_w1), 32'h1809);
    check("chain2_tail", 32'(last_w2), 32'h1809);
    check("directed_dones", dones, 1);

    // Re-pulse mid-shift is ignored
    randomize_cfg();
    l0 = loads; dn0 = dones;
    issue_xfer();
    wait_edges(60, 2000);
    @(posedge clk); #1 xfer_req = 1'b1;
    @(posedge clk); #1 xfer_req = 1'b0;
    wait_done(3000);
    repeat (30) @(posedge clk);
    #1;
    check("repulse_single_done", dones - dn0, 1);
    check("repulse_single_load", loads - l0, 1);

    // Reset at bit 100: no load, then a fresh transfer completes
    randomize_cfg();
    l0 = loads; dn0 = dones;
    issue_xfer();
    wait_edges(100, 2000);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("busy_after_mid_reset", {31'd0, busy}, 32'd0);
    check("outputs_after_mid_reset", {29'd0, sclk, sload, srstn}, 32'd0);
    exp_q1.delete();
    exp_q2.delete();
    exp_done_cyc = -1;
    // Request coincident with reset is lost
    xfer_req = 1'b1;
    @(posedge clk); #1;
    xfer_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("req_lost_under_reset", {31'd0, busy}, 32'd0);
    repeat (50) @(posedge clk);
    #1;
    check("no_load_after_abort", loads - l0, 0);
    check("no_done_after_abort", dones - dn0, 0);
    randomize_cfg();
    issue_xfer();
    wait_done(3000);
    check("fresh_xfer_load", loads - l0, 1);

    // Random scoreboard transfers over all 38 pads
    for (int t = 0; t < 3; t++) begin
      randomize_cfg();
      issue_xfer();
      wait_done(3000);
    end

    // DUT B, CLK_DIV = 0
    begin
      int c, n;
      @(posedge clk); #1;
      c = cyc;
      b_req = 1'b1;
      @(posedge clk); #1;
      b_req = 1'b0;
      n = 0;
      while (b_dones == 0 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      #1;
      check("b_done_seen", b_dones, 1);
      check("b_done_cycle", b_done_cyc, c + TOTAL_B - 1);
      check("b_edges", b_edges, 247);
      check("b_resetn_low_cycles", b_rlow, 1);
      check("b_high_longer_than_1", b_hi_long, 0);
    end

    // Bit-bang passthrough
    bb_enable = 1'b1;
    v = 1'b0;
    for (int i = 0; i < 13; i++) begin
      v = ~v;
      bb_clock = v;
      @(posedge clk); #1;
`ifdef GPIO_LOADER_BITBANG_EN
      check("bb_clock_mirror", {31'd0, sclk}, {31'd0, v});
`else
      check("bb_idle_clock", {31'd0, sclk}, 32'd0);
`endif
      check("bb_idle_resetn", {31'd0, srstn}, 32'd1);
    end
`ifdef GPIO_LOADER_BITBANG_EN
    xfer_req = 1'b1;
    @(posedge clk); #1;
    xfer_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bb_xfer_ignored", {31'd0, busy}, 32'd0);
`endif
    bb_enable = 1'b0;
    bb_clock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_bb", {29'd0, sclk, sload, srstn}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
